// File: rtl/data_break_arb.sv
// data_break_arb
//   Two-port round-robin arbiter that turns device transfer requests into
//   CPU data-break cycles. A winning request is latched (direction, address,
//   write data) and presented to the CPU together with data_break. The CPU
//   then steps through its DB1 (address) and DB2 (data) major states.
//   A one-cycle gnt pulse then tells the device that its transfer is done.
//   If the CPU never reaches DB1 within TIMEOUT_CYC clocks, the break is
//   abandoned and the sticky timeout_err flag is raised.
//
// Ports
//   clk            system clock, rising edge
//   reset, clear   synchronous active-high; clear (IOCLR) acts like reset
//   state          CPU major state
//   break_in_prog  CPU busy with another device's data break
//   dmaDIN         memory read data, valid while state == DB2_CODE
//   reqN/wrN       level request held until gntN / direction (1 = write mem)
//   addrN/wdataN   15-bit field+address / 12-bit write data
//   gnt0, gnt1     one-cycle completion pulses
//   rdata          read data, valid during the gnt pulse
//   data_break     break request to the CPU
//   to_mem         direction of the current break
//   dmaAddr        address of the current break
//   dmaDOUT        write data of the current break
//   timeout_err    sticky timeout flag
module data_break_arb #(
    parameter logic [4:0] DB1_CODE    = 5'd12,
    parameter logic [4:0] DB2_CODE    = 5'd13,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [4:0]  state,
    input  logic        break_in_prog,
    input  logic [11:0] dmaDIN,
    input  logic        req0,
    input  logic        req1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [14:0] addr0,
    input  logic [14:0] addr1,
    input  logic [11:0] wdata0,
    input  logic [11:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [11:0] rdata,
    output logic        data_break,
    output logic        to_mem,
    output logic [14:0] dmaAddr,
    output logic [11:0] dmaDOUT,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, GNT} fsm_t;

    // Counter value seen during the last permitted REQ cycle.
    localparam logic [10:0] TIMEOUT_LAST = 11'(TIMEOUT_CYC - 1);

    fsm_t        fsm_q, fsm_d;
    logic        data_break_q, data_break_d;
    logic        to_mem_q, to_mem_d;
    logic [14:0] dma_addr_q, dma_addr_d;
    logic [11:0] dma_dout_q, dma_dout_d;
    logic [11:0] rdata_q, rdata_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        timeout_err_q, timeout_err_d;
    logic [10:0] cnt_q, cnt_d;
    // last_q: requester served most recently (1 after reset so req0 leads).
    logic        last_q, last_d;
    // win_q: requester owning the outstanding break.
    logic        win_q, win_d;
    logic        pick;

    // Round-robin pick: a lone requester wins; on contention the one not
    // served last wins.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_q;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    always_comb begin
        fsm_d         = fsm_q;
        data_break_d  = data_break_q;
        to_mem_d      = to_mem_q;
        dma_addr_d    = dma_addr_q;
        dma_dout_d    = dma_dout_q;
        rdata_d       = rdata_q;
        gnt0_d        = 1'b0;
        gnt1_d        = 1'b0;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        win_d         = win_q;

        case (fsm_q)
            IDLE: begin
                if ((req0 || req1) && !break_in_prog) begin
                    win_d        = pick;
                    to_mem_d     = pick ? wr1 : wr0;
                    dma_addr_d   = pick ? addr1 : addr0;
                    dma_dout_d   = pick ? wdata1 : wdata0;
                    data_break_d = 1'b1;
                    cnt_d        = '0;
                    fsm_d        = REQ;
                end
            end
            REQ: begin
                if (state == DB1_CODE) begin
                    data_break_d = 1'b0;
                    fsm_d        = XFER;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Abandon the break but still complete the handshake so
                    // the device is not left waiting forever.
                    timeout_err_d = 1'b1;
                    data_break_d  = 1'b0;
                    rdata_d       = '0;
                    gnt0_d        = ~win_q;
                    gnt1_d        = win_q;
                    fsm_d         = GNT;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            XFER: begin
                if (state == DB2_CODE) begin
                    if (!to_mem_q) begin
                        rdata_d = dmaDIN;
                    end
                    gnt0_d = ~win_q;
                    gnt1_d = win_q;
                    fsm_d  = GNT;
                end
            end
            GNT: begin
                // The gnt pulse is visible throughout this state; requests
                // are not looked at until IDLE.
                last_d = win_q;
                fsm_d  = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            fsm_q         <= IDLE;
            data_break_q  <= 1'b0;
            to_mem_q      <= 1'b0;
            dma_addr_q    <= '0;
            dma_dout_q    <= '0;
            rdata_q       <= '0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
            last_q        <= 1'b1;
            win_q         <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            data_break_q  <= data_break_d;
            to_mem_q      <= to_mem_d;
            dma_addr_q    <= dma_addr_d;
            dma_dout_q    <= dma_dout_d;
            rdata_q       <= rdata_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            win_q         <= win_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign rdata       = rdata_q;
    assign data_break  = data_break_q;
    assign to_mem      = to_mem_q;
    assign dmaAddr     = dma_addr_q;
    assign dmaDOUT     = dma_dout_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_data_break_arb.sv
// Directed testbench for data_break_arb.
module tb_data_break_arb;

    localparam logic [4:0] DB1 = 5'd12;
    localparam logic [4:0] DB2 = 5'd13;
    localparam int         TMO = 1024;

    logic        clk = 1'b0;
    logic        reset, clear, break_in_prog;
    logic [4:0]  state;
    logic [11:0] dmaDIN;
    logic        req0, req1, wr0, wr1;
    logic [14:0] addr0, addr1;
    logic [11:0] wdata0, wdata1;
    logic        gnt0, gnt1, data_break, to_mem, timeout_err;
    logic [11:0] rdata, dmaDOUT;
    logic [14:0] dmaAddr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_break_arb #(.DB1_CODE(DB1), .DB2_CODE(DB2), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .clear(clear), .state(state),
        .break_in_prog(break_in_prog), .dmaDIN(dmaDIN),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata), .data_break(data_break),
        .to_mem(to_mem), .dmaAddr(dmaAddr), .dmaDOUT(dmaDOUT),
        .timeout_err(timeout_err)
    );

    // Advance one clock; outputs are sampled and inputs driven 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".gnt0"}, 32'(gnt0), 32'd0);
        chk({tag, ".gnt1"}, 32'(gnt1), 32'd0);
        chk({tag, ".data_break"}, 32'(data_break), 32'd0);
        chk({tag, ".to_mem"}, 32'(to_mem), 32'd0);
        chk({tag, ".dmaAddr"}, 32'(dmaAddr), 32'd0);
        chk({tag, ".dmaDOUT"}, 32'(dmaDOUT), 32'd0);
        chk({tag, ".rdata"}, 32'(rdata), 32'd0);
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; break_in_prog = 1'b0; state = 5'd0;
        dmaDIN = '0; req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick();
        tick();
        chk_idle_outputs("reset");
        reset = 1'b0;

        // Write from req0, DB1 and DB2 back to back: gnt0 in the 4th cycle.
        req0 = 1'b1; wr0 = 1'b1; addr0 = 15'o12345; wdata0 = 12'o7070;
        tick();
        chk("wr.db_set", 32'(data_break), 32'd1);
        chk("wr.addr", 32'(dmaAddr), 32'o12345);
        chk("wr.dout", 32'(dmaDOUT), 32'o7070);
        chk("wr.to_mem", 32'(to_mem), 32'd1);
        chk("wr.gnt0_c1", 32'(gnt0), 32'd0);
        state = DB1; addr0 = 15'o00111; wdata0 = 12'o0222;
        tick();
        chk("wr.db_clr", 32'(data_break), 32'd0);
        chk("wr.gnt0_c2", 32'(gnt0), 32'd0);
        chk("wr.addr_hold", 32'(dmaAddr), 32'o12345);
        state = DB2;
        tick();
        chk("wr.gnt0", 32'(gnt0), 32'd1);
        chk("wr.gnt1", 32'(gnt1), 32'd0);
        chk("wr.dout_hold", 32'(dmaDOUT), 32'o7070);
        chk("wr.rdata_keep", 32'(rdata), 32'd0);
        state = 5'd0; req0 = 1'b0;
        tick();
        chk("wr.gnt0_end", 32'(gnt0), 32'd0);

        // Read from req1.
        req1 = 1'b1; wr1 = 1'b0; addr1 = 15'o00200;
        tick();
        chk("rd.db_set", 32'(data_break), 32'd1);
        chk("rd.addr", 32'(dmaAddr), 32'o00200);
        chk("rd.to_mem", 32'(to_mem), 32'd0);
        state = DB1;
        tick();
        state = DB2; dmaDIN = 12'o4321;
        tick();
        chk("rd.gnt1", 32'(gnt1), 32'd1);
        chk("rd.gnt0", 32'(gnt0), 32'd0);
        chk("rd.rdata", 32'(rdata), 32'o4321);
        state = 5'd0; dmaDIN = '0; req1 = 1'b0;
        tick();
        chk("rd.gnt1_end", 32'(gnt1), 32'd0);
        chk("rd.rdata_keep", 32'(rdata), 32'o4321);

        // Both held for four transfers: alternating 0,1,0,1.
        req0 = 1'b1; req1 = 1'b1; wr0 = 1'b1; wr1 = 1'b0;
        addr0 = 15'o00001; addr1 = 15'o00002; dmaDIN = 12'o0555;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr%0d.addr", i), 32'(dmaAddr), (i % 2 == 0) ? 32'o1 : 32'o2);
            chk($sformatf("rr%0d.to_mem", i), 32'(to_mem), (i % 2 == 0) ? 32'd1 : 32'd0);
            state = DB1;
            tick();
            state = DB2;
            tick();
            chk($sformatf("rr%0d.gnt0", i), 32'(gnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d.gnt1", i), 32'(gnt1), (i % 2 == 0) ? 32'd0 : 32'd1);
            state = 5'd0;
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr.rdata", 32'(rdata), 32'o0555);

        // Timeout: CPU never reaches DB1.
        req0 = 1'b1; wr0 = 1'b0; addr0 = 15'o00005;
        tick();
        chk("tmo.db_set", 32'(data_break), 32'd1);
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("tmo.db_before", 32'(data_break), 32'd1);
        chk("tmo.err_before", 32'(timeout_err), 32'd0);
        tick();
        chk("tmo.err", 32'(timeout_err), 32'd1);
        chk("tmo.db_clr", 32'(data_break), 32'd0);
        chk("tmo.gnt0", 32'(gnt0), 32'd1);
        chk("tmo.rdata", 32'(rdata), 32'd0);
        req0 = 1'b0;
        tick();
        tick();
        tick();
        chk("tmo.gnt0_end", 32'(gnt0), 32'd0);
        chk("tmo.err_hold", 32'(timeout_err), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("tmo.err_clr", 32'(timeout_err), 32'd0);

        // clear during XFER aborts without gnt; break_in_prog blocks start.
        req1 = 1'b1; wr1 = 1'b1; addr1 = 15'o00777; wdata1 = 12'o1234;
        tick();
        chk("clr.db_set", 32'(data_break), 32'd1);
        state = DB1;
        tick();
        state = 5'd0; clear = 1'b1; break_in_prog = 1'b1;
        tick();
        clear = 1'b0;
        chk_idle_outputs("clr");
        state = DB2;
        tick();
        chk("bip.gnt1", 32'(gnt1), 32'd0);
        chk("bip.db", 32'(data_break), 32'd0);
        state = 5'd0;
        tick();
        chk("bip.db2", 32'(data_break), 32'd0);
        chk("bip.addr", 32'(dmaAddr), 32'd0);
        break_in_prog = 1'b0;
        tick();
        chk("bip.db_set", 32'(data_break), 32'd1);
        chk("bip.addr_set", 32'(dmaAddr), 32'o00777);
        chk("bip.to_mem", 32'(to_mem), 32'd1);
        state = DB1;
        tick();
        state = DB2;
        tick();
        chk("bip.gnt1_pulse", 32'(gnt1), 32'd1);
        chk("bip.gnt0_pulse", 32'(gnt0), 32'd0);
        state = 5'd0; req1 = 1'b0;
        tick();

        // reset in the same cycle as DB2 wins: no gnt.
        req0 = 1'b1; wr0 = 1'b1; addr0 = 15'o00042;
        tick();
        state = DB1;
        tick();
        state = DB2; reset = 1'b1;
        tick();
        chk("rst.gnt0", 32'(gnt0), 32'd0);
        chk("rst.addr", 32'(dmaAddr), 32'd0);
        reset = 1'b0; state = 5'd0; req0 = 1'b0;
        tick();
        chk("rst.gnt0_after", 32'(gnt0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
